mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store).
- Latches the granted request and drives the memory port with a req/ack handshake.
- Returns read data with a one-cycle valid pulse and generates the stall signals the pipeline uses to freeze IF/ID and PC or the later stages.
- Data has priority; a burst limit prevents fetch starvation, and a watchdog aborts hung transactions.

Parameters:
- MAX_DATA_BURST, 4: consecutive data grants allowed while if_req is pending before one fetch grant is forced.
- TIMEOUT, 16: cycles in a busy state without mem_ack before the transaction is aborted.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched instruction
- if_valid  out  1  one-cycle pulse, fetch complete
- if_stall  out  1  fetch pending, not complete
- d_req  in  1  data request, held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 word, 01 halfword, 10 byte
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_rdata  out  32  load data
- d_valid  out  1  one-cycle pulse, data access complete
- d_stall  out  1  data pending, not complete
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_size  out  2  access size
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- mem_ack  in  1  memory completion, one cycle
- err  out  1  sticky timeout flag

Behaviour:
- Reset (async): state IDLE, burst_cnt 0, timer 0. All outputs are 0, including if_rdata, d_rdata and err.
- States: IDLE, FETCH, DATA. All mem_* outputs are registered and are zero in IDLE.
- IDLE arbitration at each clk edge:
  - d_req and if_req both high, burst_cnt == MAX_DATA_BURST → FETCH.
  - Otherwise d_req → DATA.
  - Otherwise if_req → FETCH.
  - Neither → stay in IDLE.
- On a grant, the request is latched. Fetch: mem_addr = {if_addr[31:2], 2'b00}, mem_size = 00, mem_we = 0. Data: d_addr, d_size, d_we, d_wdata unmodified.
- mem_req is 1 throughout FETCH/DATA, from the grant edge until the edge that samples mem_ack.
- Burst counter:
  - A data grant with if_req high increments burst_cnt, saturating at MAX_DATA_BURST.
  - A data grant with if_req low clears it.
  - A fetch grant clears it.
- Completion (mem_ack sampled in FETCH/DATA) → IDLE, with mem_* cleared.
  - Fetch: if_rdata ← mem_rdata, if_valid = 1 for one cycle.
  - Load: d_rdata ← mem_rdata, d_valid = 1 for one cycle.
  - Store: d_valid pulses; d_rdata holds its previous value.
- Latency with zero-wait memory (ack in the first cycle mem_req is high): request sampled at edge N, valid high after edge N+1. Each extra wait cycle adds one. There is always one IDLE cycle between transactions, and that cycle is the valid cycle.
- Stalls are combinational:
  - if_stall = if_req & ~if_valid
  - d_stall = d_req & ~d_valid
- Request held high in its valid cycle: sampled in IDLE as a new request, since the pipeline presents the next address then.
- Request dropped mid-transaction: the transaction still completes and the valid pulse still occurs; the requester ignores it.
- mem_ack in IDLE is ignored and produces no valid pulse.
- Timeout: the timer counts cycles in FETCH/DATA and clears in IDLE. If timer reaches TIMEOUT with no ack:
  - Return to IDLE and drop mem_req.
  - Set err (sticky until reset).
  - Pulse the owner's valid with its rdata = 32'h0.
- Reset mid-transaction: mem_req drops immediately (async), no valid pulse occurs, and a late ack after reset is ignored.

Test Plan:
- Fetch only, memory acks in first cycle of mem_req: if_addr = 0x0000_0106 → mem_addr 0x0000_0104, mem_size 00; with mem_rdata 0xE3A0_1005, if_valid pulses two cycles after request with if_rdata 0xE3A0_1005; if_stall high exactly two cycles.
- Simultaneous if_req and d_req (store, d_addr 0x40, d_wdata 0x1234, d_size 10), memory acks in first cycle of mem_req: DATA granted first with mem_we 1 and mem_size 10; then FETCH; d_valid pulses at cycle 2, if_valid at cycle 4.
- d_req and if_req held continuously with MAX_DATA_BURST 4: grant order D, D, D, D, F, D…; burst_cnt resets after F.
- Memory acks after 3 wait cycles on a load: mem_req high for 4 cycles; d_rdata is captured only on the ack edge; d_stall remains high until d_valid.
- No ack for 16 cycles: err rises; d_valid pulses with d_rdata 0; next request proceeds normally; err stays 1 until reset.
- Reset asserted in the 2nd wait cycle of a fetch, with ack one cycle later: outputs clear immediately; no if_valid; state IDLE; new fetch after reset completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, variable-latency memory between instruction
//   fetch (read-only) and the data stage (load/store). Data requests win
//   arbitration, except that after MAX_DATA_BURST back-to-back data grants
//   with a fetch waiting, one fetch grant is forced. A watchdog aborts any
//   transaction that sees no mem_ack within TIMEOUT busy cycles.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   if_req/if_addr        fetch request (held until if_valid) and byte address
//   if_rdata/if_valid     fetched word and its one-cycle completion pulse
//   if_stall              fetch outstanding, not yet complete (combinational)
//   d_req/d_we/d_size     data request, 1 = store, size 00 word/01 half/10 byte
//   d_addr/d_wdata        data byte address and store data
//   d_rdata/d_valid       load data and one-cycle completion pulse
//   d_stall               data access outstanding, not yet complete
//   mem_req..mem_wdata    registered memory command, all zero when idle
//   mem_rdata/mem_ack     memory read data and one-cycle completion
//   err                   sticky watchdog-timeout flag
module mem_port_arbiter #(
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  localparam int BW = $clog2(MAX_DATA_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);
  // Abort on the last permitted busy cycle, so mem_req is high for exactly
  // TIMEOUT cycles when no ack ever arrives.
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  // Latched memory command; the whole struct is zero while idle.
  typedef struct packed {
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  state_t        state, state_nxt;
  mem_cmd_t      cmd, cmd_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [31:0]   if_rdata_nxt, d_rdata_nxt;
  logic          if_valid_nxt, d_valid_nxt, err_nxt;
  logic          force_fetch;
  logic          unused_addr_bits;

  // Fetches are always word aligned; the low address bits are dropped.
  assign unused_addr_bits = ^if_addr[1:0];

  assign force_fetch = d_req & if_req & (burst_cnt == BURST_MAX);

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd       <= '0;
      burst_cnt <= '0;
      timer     <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd       <= cmd_nxt;
      burst_cnt <= burst_nxt;
      timer     <= timer_nxt;
      if_rdata  <= if_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      if_valid  <= if_valid_nxt;
      d_valid   <= d_valid_nxt;
      err       <= err_nxt;
    end
  end

  // Arbitration, completion and watchdog.
  always_comb begin
    state_nxt    = state;
    cmd_nxt      = cmd;
    burst_nxt    = burst_cnt;
    timer_nxt    = '0;
    if_rdata_nxt = if_rdata;
    d_rdata_nxt  = d_rdata;
    if_valid_nxt = 1'b0;
    d_valid_nxt  = 1'b0;
    err_nxt      = err;

    unique case (state)
      IDLE: begin
        // mem_ack here belongs to nothing (e.g. a reset-orphaned access).
        cmd_nxt = '0;
        if (force_fetch || (if_req && !d_req)) begin
          state_nxt      = FETCH;
          cmd_nxt.req    = 1'b1;
          cmd_nxt.we     = 1'b0;
          cmd_nxt.size   = 2'b00;
          cmd_nxt.addr   = {if_addr[31:2], 2'b00};
          cmd_nxt.wdata  = '0;
          burst_nxt      = '0;
        end else if (d_req) begin
          state_nxt      = DATA;
          cmd_nxt.req    = 1'b1;
          cmd_nxt.we     = d_we;
          cmd_nxt.size   = d_size;
          cmd_nxt.addr   = d_addr;
          cmd_nxt.wdata  = d_wdata;
          // Only a data grant that bypassed a waiting fetch counts.
          if (!if_req)
            burst_nxt = '0;
          else if (burst_cnt != BURST_MAX)
            burst_nxt = burst_cnt + BW'(1);
        end
      end

      FETCH, DATA: begin
        if (mem_ack) begin
          state_nxt = IDLE;
          cmd_nxt   = '0;
          if (state == FETCH) begin
            if_valid_nxt = 1'b1;
            if_rdata_nxt = mem_rdata;
          end else begin
            d_valid_nxt = 1'b1;
            // Stores leave the last load result untouched.
            if (!cmd.we)
              d_rdata_nxt = mem_rdata;
          end
        end else if (timer == TMO_LAST) begin
          // Hung memory: release the owner with zero data and flag it.
          state_nxt = IDLE;
          cmd_nxt   = '0;
          err_nxt   = 1'b1;
          if (state == FETCH) begin
            if_valid_nxt = 1'b1;
            if_rdata_nxt = '0;
          end else begin
            d_valid_nxt = 1'b1;
            d_rdata_nxt = '0;
          end
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        cmd_nxt   = '0;
      end
    endcase
  end

  assign mem_req   = cmd.req;
  assign mem_we    = cmd.we;
  assign mem_size  = cmd.size;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;

  // Stalls fall in the valid cycle so the pipeline advances on that edge.
  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid, if_stall;
  logic        d_req, d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_valid, d_stall;
  logic        mem_req, mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, err;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.MAX_DATA_BURST(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0;
    d_addr = 0; d_wdata = 0; mem_rdata = 0; mem_ack = 0;
    #2;
    checks++;
    if ({mem_req, mem_we, mem_size, mem_addr, mem_wdata} !== 68'h0) begin
      failures++;
      $display("FAIL reset_mem: got %h expected 0", {mem_req, mem_we, mem_size, mem_addr, mem_wdata});
    end
    checks++;
    if ({if_rdata, d_rdata, if_valid, d_valid, err, if_stall, d_stall} !== 69'h0) begin
      failures++;
      $display("FAIL reset_out: got %h expected 0", {if_rdata, d_rdata, if_valid, d_valid, err, if_stall, d_stall});
    end
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b0;
    tick();
    checks++;
    if ({mem_req, if_valid, d_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle: got %b expected 000", {mem_req, if_valid, d_valid});
    end
  endtask

  task automatic test_fetch();
    int stall_cycles = 0;
    if_req = 1; if_addr = 32'h0000_0106; mem_rdata = 32'hE3A0_1005;
    #1; if (if_stall) stall_cycles++;
    tick();
    if (if_stall) stall_cycles++;
    checks++;
    if ({mem_req, mem_we, mem_size, mem_addr} !== {1'b1, 1'b0, 2'b00, 32'h0000_0104}) begin
      failures++;
      $display("FAIL fetch_cmd: got req=%b we=%b size=%b addr=%h expected 1 0 00 00000104",
               mem_req, mem_we, mem_size, mem_addr);
    end
    checks++;
    if (if_valid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_early_valid: got %b expected 0", if_valid);
    end
    mem_ack = 1;
    tick();
    if (if_stall) stall_cycles++;
    checks++;
    if ({if_valid, if_rdata, mem_req} !== {1'b1, 32'hE3A0_1005, 1'b0}) begin
      failures++;
      $display("FAIL fetch_done: got valid=%b rdata=%h req=%b expected 1 e3a01005 0",
               if_valid, if_rdata, mem_req);
    end
    mem_ack = 0; if_req = 0;
    tick();
    checks++;
    if ({if_valid, mem_req} !== 2'b00) begin
      failures++;
      $display("FAIL fetch_pulse: got valid=%b req=%b expected 0 0", if_valid, mem_req);
    end
    checks++;
    if (stall_cycles !== 2) begin
      failures++;
      $display("FAIL fetch_stall_cycles: got %0d expected 2", stall_cycles);
    end
  endtask

  task automatic test_simultaneous();
    if_req = 1; if_addr = 32'h0000_0200;
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h1234; d_size = 2'b10;
    mem_rdata = 32'hDEAD_BEEF;
    tick(); // cycle 1
    checks++;
    if ({mem_req, mem_we, mem_size, mem_addr, mem_wdata} !== {1'b1, 1'b1, 2'b10, 32'h40, 32'h1234}) begin
      failures++;
      $display("FAIL simul_data_cmd: got req=%b we=%b size=%b addr=%h wdata=%h expected 1 1 10 00000040 00001234",
               mem_req, mem_we, mem_size, mem_addr, mem_wdata);
    end
    mem_ack = 1;
    tick(); // cycle 2
    checks++;
    if ({d_valid, d_stall, d_rdata, if_stall} !== {1'b1, 1'b0, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL simul_store_done: got valid=%b stall=%b rdata=%h if_stall=%b expected 1 0 00000000 1",
               d_valid, d_stall, d_rdata, if_stall);
    end
    d_req = 0; mem_ack = 0;
    tick(); // cycle 3
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h200}) begin
      failures++;
      $display("FAIL simul_fetch_cmd: got req=%b we=%b addr=%h expected 1 0 00000200", mem_req, mem_we, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'h0000_00AB;
    tick(); // cycle 4
    checks++;
    if ({if_valid, if_rdata} !== {1'b1, 32'hAB}) begin
      failures++;
      $display("FAIL simul_fetch_done: got valid=%b rdata=%h expected 1 000000ab", if_valid, if_rdata);
    end
    if_req = 0; mem_ack = 0;
    tick();
  endtask

  task automatic test_burst();
    string seq = "";
    string c;
    d_req = 1; d_we = 0; d_size = 2'b00; d_addr = 32'h2000;
    if_req = 1; if_addr = 32'h1000; mem_rdata = 32'hCAFE_0001;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (mem_req) begin
        c = (mem_addr == 32'h1000) ? "F" : "D";
        seq = {seq, c};
        mem_ack = 1;
      end else begin
        mem_ack = 0;
      end
    end
    d_req = 0; if_req = 0; mem_ack = 0;
    checks++;
    if (seq != "DDDDFDDDDFDD") begin
      failures++;
      $display("FAIL burst_order: got %s expected DDDDFDDDDFDD", seq);
    end
    checks++;
    if (d_rdata !== 32'hCAFE_0001) begin
      failures++;
      $display("FAIL burst_load_data: got %h expected cafe0001", d_rdata);
    end
    tick();
  endtask

  task automatic test_wait_load();
    int req_cycles = 0;
    d_req = 1; d_we = 0; d_size = 2'b00; d_addr = 32'h80; mem_rdata = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_req) req_cycles++;
      checks++;
      if ({d_stall, d_valid, d_rdata} !== {1'b1, 1'b0, 32'hCAFE_0001}) begin
        failures++;
        $display("FAIL wait_cycle%0d: got stall=%b valid=%b rdata=%h expected 1 0 cafe0001",
                 i, d_stall, d_valid, d_rdata);
      end
    end
    tick();
    if (mem_req) req_cycles++;
    mem_rdata = 32'h5555_AAAA; mem_ack = 1;
    tick();
    checks++;
    if ({d_valid, d_stall, d_rdata, mem_req} !== {1'b1, 1'b0, 32'h5555_AAAA, 1'b0}) begin
      failures++;
      $display("FAIL wait_done: got valid=%b stall=%b rdata=%h req=%b expected 1 0 5555aaaa 0",
               d_valid, d_stall, d_rdata, mem_req);
    end
    checks++;
    if (req_cycles !== 4) begin
      failures++;
      $display("FAIL wait_req_cycles: got %0d expected 4", req_cycles);
    end
    d_req = 0; mem_ack = 0;
    tick();
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    bit got = 0;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_err_before: got %b expected 0", err);
    end
    d_req = 1; d_we = 0; d_addr = 32'h90; mem_rdata = 32'h7777_7777;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (d_valid) begin
        got = 1;
        break;
      end
      if (mem_req) req_cycles++;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL tmo_no_valid: got no d_valid expected pulse within 40 cycles");
    end
    checks++;
    if ({err, d_rdata, mem_req} !== {1'b1, 32'h0, 1'b0} || req_cycles !== 16) begin
      failures++;
      $display("FAIL tmo_abort: got err=%b rdata=%h req=%b busy=%0d expected 1 00000000 0 16",
               err, d_rdata, mem_req, req_cycles);
    end
    d_req = 0;
    if_req = 1; if_addr = 32'h300; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ack = 1;
    tick();
    checks++;
    if ({if_valid, if_rdata, err} !== {1'b1, 32'h0BAD_F00D, 1'b1}) begin
      failures++;
      $display("FAIL tmo_recover: got valid=%b rdata=%h err=%b expected 1 0badf00d 1", if_valid, if_rdata, err);
    end
    if_req = 0; mem_ack = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    if_req = 1; if_addr = 32'h400; mem_rdata = 32'h2468_ACE0;
    tick(); // first wait cycle
    tick(); // second wait cycle
    reset = 1;
    if_req = 0;
    #1;
    checks++;
    if ({mem_req, mem_addr, if_valid, err} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid_clear: got req=%b addr=%h valid=%b err=%b expected 0 0 0 0",
               mem_req, mem_addr, if_valid, err);
    end
    #1 reset = 0;
    tick();
    mem_ack = 1; // late ack for the orphaned fetch
    tick();
    checks++;
    if ({if_valid, if_rdata, mem_req} !== {1'b0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL rst_late_ack: got valid=%b rdata=%h req=%b expected 0 00000000 0", if_valid, if_rdata, mem_req);
    end
    mem_ack = 0;
    if_req = 1; if_addr = 32'h504; mem_rdata = 32'h1357_9BDF;
    tick();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h504}) begin
      failures++;
      $display("FAIL rst_new_cmd: got req=%b addr=%h expected 1 00000504", mem_req, mem_addr);
    end
    mem_ack = 1;
    tick();
    checks++;
    if ({if_valid, if_rdata} !== {1'b1, 32'h1357_9BDF}) begin
      failures++;
      $display("FAIL rst_new_done: got valid=%b rdata=%h expected 1 13579bdf", if_valid, if_rdata);
    end
    if_req = 0; mem_ack = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_burst();
    test_wait_load();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
